irsender_wb8: RTL and testbench
===============================

// Module: irsender_wb8
// PURPOSE
//  NEC-protocol infrared transmitter: the sending counterpart of irdecoder_wb8. It is an 8-bit Wishbone
//  responder decoded at 0xFFFFFBxx (reserved slot), addressed via cpu_adr[2:0].
//  The CPU loads address/command bytes and starts a frame or repeat code; the block generates the
//  pulse-distance envelope and the 38 kHz carrier on O_ir_led.
// PARAMETERS
//  CLOCKFREQ    25125000  system clock in Hz; UNIT_TICKS = CLOCKFREQ*9/16000 (562.5 us, truncated)
//  CARRIERFREQ  38000     carrier in Hz; HALF_TICKS = CLOCKFREQ/(2*CARRIERFREQ) (truncated)
// PORTS
//  I_wb_clk   in   1  system clock
//  I_reset    in   1  synchronous, active-high reset
//  I_wb_adr   in   3  register select
//  I_wb_dat   in   8  write data
//  I_wb_stb   in   1  strobe
//  I_wb_we    in   1  write enable
//  O_wb_dat   out  8  read data, registered
//  O_wb_ack   out  1  ack, registered
//  O_ir_led   out  1  IR LED drive, active high
// BEHAVIOUR
//  Reset: O_ir_led=0, O_wb_ack=0, O_wb_dat=0, all registers 0, FSM=IDLE; aborts any frame at that edge.
//  Bus: O_wb_ack <= I_wb_stb every cycle. Read data is valid with ack. No stall, no wait states.
//  Registers: 0 ADDR rw; 1 ADDR_HI rw; 2 CMD rw; 3 CTRL.
//   CTRL write: b0 START_FRAME, b1 START_REPEAT, b2 EXT.
//   CTRL read: b0 BUSY, b2 EXT, b7 DONE. Offsets 4-7 read 0 and ignore writes.
//  START: accepted only in IDLE. A write while BUSY is ignored, and EXT is still updated.
//   b0 and b1 both set -> frame wins. Accepted START clears DONE.
//  Frame start: 32-bit shift reg <= {~CMD, CMD, EXT ? ADDR_HI : ~ADDR, ADDR}, sent LSB first.
//   Registers may be rewritten during a frame without affecting it.
//  FSM (durations in units of UNIT_TICKS, unit counter restarts on every state entry):
//   IDLE -> LEADER_MARK(16) -> LEADER_SPACE(8) -> BIT_MARK(1) -> BIT_SPACE(1 if bit=0, 3 if bit=1).
//   After BIT_SPACE: next BIT_MARK for bits 0..30; STOP_MARK(1) after bit 31; STOP_MARK -> IDLE.
//   Repeat: IDLE -> LEADER_MARK(16) -> REP_SPACE(4) -> STOP_MARK(1) -> IDLE.
//  BUSY=1 from the cycle after the accepted START until the cycle FSM re-enters IDLE. DONE set on that
//   same cycle; sticky until next accepted START or reset. No trailing gap is enforced; software paces frames.
//  Envelope=1 in *_MARK states. Carrier counter restarts on mark entry, so first carrier half-period is high.
//   It toggles every HALF_TICKS and is held at 0 in spaces and IDLE.
//  Counters: unit counter 16 bits, carrier counter 12 bits, bit index 5 bits (wraps 31->0 only on frame end).
// CONFIGURATION
//  IRSENDER_CARRIER_EN defined: O_ir_led = envelope AND carrier.
//  Not defined: O_ir_led = envelope (raw, for an external modulator or loopback into irdecoder_wb8).
//   Carrier generator is not instantiated.
// STRUCTURE
//  Shared header irsender_defs.vh: register offsets, CTRL bit positions, state encodings,
//   unit counts (16,8,4,3,1), frame bit count 32.
//  One sub-module: ir_carrier_gen (HALF_TICKS param; I_wb_clk, I_reset, I_enable -> O_carrier).
//  FSM, shift register, and Wishbone regs in irsender_wb8.
// TESTING (bench with CLOCKFREQ=160000, CARRIERFREQ=8000 -> UNIT_TICKS=90, HALF_TICKS=10)
//  1 ADDR=0x00, CMD=0x45, CTRL=0x01 -> leader 1440 mark/720 space.
//    Bits FF/45/BA LSB first: 16 ones, 16 zeros. Stop mark. Total 121 units = 10890 cycles, then BUSY=0, DONE=1.
//  2 CTRL=0x02 -> 1440 mark, 360 space, 90 mark, IDLE; CTRL reads 0x80.
//  3 EXT: ADDR=0x12, ADDR_HI=0x34, CMD=0x01, CTRL=0x05 -> second byte sent is 0x34, not 0xED;
//    envelope decodes through irdecoder_wb8 loopback.
//  4 CTRL=0x01 written again at cycle 500 of a frame -> ignored; frame length is still 10890 cycles.
//    CTRL=0x03 in IDLE -> full frame sent.
//  5 I_reset=1 during bit 10 mark -> next edge O_ir_led=0, CTRL reads 0x00.
//    New START after reset sends a complete frame.
//  6 Carrier on (IRSENDER_CARRIER_EN) -> 20-cycle period, high first 10 cycles of each mark; 0 in spaces.
//    Off -> O_ir_led equals envelope.

Source files
------------

// File: rtl/irsender_wb8_pkg.sv
// Shared definitions for the NEC infrared transmitter: register map, CTRL bit
// positions, FSM state encoding, per-state unit counts and timing helpers.
package irsender_wb8_pkg;

   // Register offsets selected by the 3-bit bus address
   localparam logic [2:0] REG_ADDR    = 3'd0;
   localparam logic [2:0] REG_ADDR_HI = 3'd1;
   localparam logic [2:0] REG_CMD     = 3'd2;
   localparam logic [2:0] REG_CTRL    = 3'd3;

   // CTRL bit positions (write side: starts and EXT; read side: BUSY, EXT, DONE)
   localparam int CTRL_START_FRAME  = 0;
   localparam int CTRL_START_REPEAT = 1;
   localparam int CTRL_EXT          = 2;
   localparam int CTRL_BUSY         = 0;
   localparam int CTRL_DONE         = 7;

   // Segment lengths in protocol units of 562.5 us
   localparam logic [4:0] UNITS_LEADER_MARK  = 5'd16;
   localparam logic [4:0] UNITS_LEADER_SPACE = 5'd8;
   localparam logic [4:0] UNITS_REP_SPACE    = 5'd4;
   localparam logic [4:0] UNITS_ONE_SPACE    = 5'd3;
   localparam logic [4:0] UNITS_SHORT        = 5'd1;

   localparam int FRAME_BITS = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEADER_MARK,
      ST_LEADER_SPACE,
      ST_REP_SPACE,
      ST_BIT_MARK,
      ST_BIT_SPACE,
      ST_STOP_MARK
   } state_e;

   // Clock cycles in one 562.5 us protocol unit (truncated)
   function automatic int unit_ticks(input int clockfreq);
      return (clockfreq * 9) / 16000;
   endfunction

   // Clock cycles in one half period of the carrier (truncated)
   function automatic int half_ticks(input int clockfreq, input int carrierfreq);
      return clockfreq / (2 * carrierfreq);
   endfunction

endpackage

// File: rtl/irsender_wb8_if.sv
// 8-bit Wishbone responder bus for the infrared transmitter.
interface irsender_wb8_if;
   logic [2:0] I_wb_adr;
   logic [7:0] I_wb_dat;
   logic       I_wb_stb;
   logic       I_wb_we;
   logic [7:0] O_wb_dat;
   logic       O_wb_ack;

   modport master (
      output I_wb_adr, I_wb_dat, I_wb_stb, I_wb_we,
      input  O_wb_dat, O_wb_ack
   );

   modport slave (
      input  I_wb_adr, I_wb_dat, I_wb_stb, I_wb_we,
      output O_wb_dat, O_wb_ack
   );
endinterface

// File: rtl/irsender_wb8_ir_carrier_gen.sv
// Carrier generator: square wave that starts high whenever I_enable rises and
// toggles every HALF_TICKS cycles; held low while disabled.
module ir_carrier_gen #(
   parameter int HALF_TICKS = 330
) (
   input  logic I_wb_clk,
   input  logic I_reset,
   input  logic I_enable,
   output logic O_carrier
);

   localparam logic [11:0] HALF_LAST = 12'(HALF_TICKS - 1);

   logic [11:0] cnt_q;
   logic        phase_q;

   // Half-period counter; restarts while disabled so each mark begins high
   always_ff @(posedge I_wb_clk) begin
      if (I_reset || !I_enable) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else if (cnt_q == HALF_LAST) begin
         cnt_q   <= '0;
         phase_q <= ~phase_q;
      end else begin
         cnt_q <= cnt_q + 12'd1;
      end
   end

   assign O_carrier = I_enable & ~phase_q;

endmodule

// File: rtl/irsender_wb8.sv
// NEC infrared transmitter with an 8-bit Wishbone register interface.
// Build option: IRSENDER_CARRIER_EN modulates the envelope with the carrier;
// without it O_ir_led carries the raw envelope and no carrier logic exists.
module irsender_wb8
   import irsender_wb8_pkg::*;
#(
   parameter int CLOCKFREQ   = 25125000,
   parameter int CARRIERFREQ = 38000
) (
   input  logic           I_wb_clk,
   input  logic           I_reset,
   irsender_wb8_if.slave  wb,
   output logic           O_ir_led
);

   localparam logic [15:0] UNIT_LAST = 16'(unit_ticks(CLOCKFREQ) - 1);

   state_e      state_q, state_d;
   logic [15:0] tick_q;
   logic [4:0]  units_q;
   logic [4:0]  bit_idx_q;
   logic [31:0] shift_q;
   logic        rep_q;
   logic [7:0]  addr_q, addr_hi_q, cmd_q;
   logic        ext_q, done_q;
   logic        ack_q;
   logic [7:0]  rdat_q, rdat_d;

   logic        ctrl_wr, start_frame, start_repeat;
   logic [4:0]  dur_units;
   logic        unit_end, seg_end, envelope, busy;

   assign ctrl_wr      = wb.I_wb_stb && wb.I_wb_we && (wb.I_wb_adr == REG_CTRL);
   assign start_frame  = ctrl_wr && (state_q == ST_IDLE) && wb.I_wb_dat[CTRL_START_FRAME];
   assign start_repeat = ctrl_wr && (state_q == ST_IDLE) && !wb.I_wb_dat[CTRL_START_FRAME]
                         && wb.I_wb_dat[CTRL_START_REPEAT];
   assign busy         = (state_q != ST_IDLE);

   // Segment length of the current state, end-of-segment detect and next state
   always_comb begin
      state_d   = state_q;
      dur_units = UNITS_SHORT;
      envelope  = 1'b0;
      case (state_q)
         ST_LEADER_MARK:  dur_units = UNITS_LEADER_MARK;
         ST_LEADER_SPACE: dur_units = UNITS_LEADER_SPACE;
         ST_REP_SPACE:    dur_units = UNITS_REP_SPACE;
         ST_BIT_SPACE:    dur_units = shift_q[0] ? UNITS_ONE_SPACE : UNITS_SHORT;
         default:         dur_units = UNITS_SHORT;
      endcase
      unit_end = (tick_q == UNIT_LAST);
      seg_end  = unit_end && (units_q == dur_units - 5'd1);
      case (state_q)
         ST_IDLE:         if (start_frame || start_repeat) state_d = ST_LEADER_MARK;
         ST_LEADER_MARK:  if (seg_end) state_d = rep_q ? ST_REP_SPACE : ST_LEADER_SPACE;
         ST_LEADER_SPACE: if (seg_end) state_d = ST_BIT_MARK;
         ST_REP_SPACE:    if (seg_end) state_d = ST_STOP_MARK;
         ST_BIT_MARK:     if (seg_end) state_d = ST_BIT_SPACE;
         ST_BIT_SPACE:    if (seg_end) state_d = (bit_idx_q == 5'(FRAME_BITS - 1)) ? ST_STOP_MARK
                                                                                 : ST_BIT_MARK;
         ST_STOP_MARK:    if (seg_end) state_d = ST_IDLE;
         default:         state_d = ST_IDLE;
      endcase
      envelope = (state_q == ST_LEADER_MARK) || (state_q == ST_BIT_MARK) ||
                 (state_q == ST_STOP_MARK);
   end

   // FSM state register; reset aborts any frame in progress
   always_ff @(posedge I_wb_clk) begin
      if (I_reset) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Read data mux, sampled into the registered read port
   always_comb begin
      rdat_d = 8'h00;
      case (wb.I_wb_adr)
         REG_ADDR:    rdat_d = addr_q;
         REG_ADDR_HI: rdat_d = addr_hi_q;
         REG_CMD:     rdat_d = cmd_q;
         REG_CTRL: begin
            rdat_d[CTRL_BUSY] = busy;
            rdat_d[CTRL_EXT]  = ext_q;
            rdat_d[CTRL_DONE] = done_q;
         end
         default:     rdat_d = 8'h00;
      endcase
   end

   // Bus registers, frame shift register and unit timing counters
   always_ff @(posedge I_wb_clk) begin
      if (I_reset) begin
         ack_q     <= 1'b0;
         rdat_q    <= '0;
         addr_q    <= '0;
         addr_hi_q <= '0;
         cmd_q     <= '0;
         ext_q     <= 1'b0;
         done_q    <= 1'b0;
         rep_q     <= 1'b0;
         shift_q   <= '0;
         bit_idx_q <= '0;
         tick_q    <= '0;
         units_q   <= '0;
      end else begin
         ack_q  <= wb.I_wb_stb;
         rdat_q <= rdat_d;
         if (wb.I_wb_stb && wb.I_wb_we) begin
            case (wb.I_wb_adr)
               REG_ADDR:    addr_q    <= wb.I_wb_dat;
               REG_ADDR_HI: addr_hi_q <= wb.I_wb_dat;
               REG_CMD:     cmd_q     <= wb.I_wb_dat;
               REG_CTRL:    ext_q     <= wb.I_wb_dat[CTRL_EXT];
               default:     ;
            endcase
         end
         // The frame word is captured at start so later register writes do not disturb it
         if (start_frame || start_repeat) begin
            done_q    <= 1'b0;
            rep_q     <= start_repeat;
            bit_idx_q <= '0;
            shift_q   <= {~cmd_q, cmd_q,
                          wb.I_wb_dat[CTRL_EXT] ? addr_hi_q : ~addr_q, addr_q};
         end else if ((state_q == ST_BIT_SPACE) && seg_end) begin
            shift_q   <= {1'b0, shift_q[31:1]};
            bit_idx_q <= bit_idx_q + 5'd1;
         end
         if ((state_q == ST_STOP_MARK) && seg_end) done_q <= 1'b1;
         // Counters restart on every state entry and stay cleared while idle
         if ((state_q == ST_IDLE) || seg_end) begin
            tick_q  <= '0;
            units_q <= '0;
         end else if (unit_end) begin
            tick_q  <= '0;
            units_q <= units_q + 5'd1;
         end else begin
            tick_q  <= tick_q + 16'd1;
         end
      end
   end

   assign wb.O_wb_ack = ack_q;
   assign wb.O_wb_dat = rdat_q;

`ifdef IRSENDER_CARRIER_EN
   logic carrier;

   ir_carrier_gen #(
      .HALF_TICKS (half_ticks(CLOCKFREQ, CARRIERFREQ))
   ) u_carrier (
      .I_wb_clk  (I_wb_clk),
      .I_reset   (I_reset),
      .I_enable  (envelope),
      .O_carrier (carrier)
   );

   assign O_ir_led = envelope & carrier;
`else
   assign O_ir_led = envelope;
`endif

endmodule

// File: tb/tb_irsender_wb8.sv
// Bench for irsender_wb8: a waveform model expands each frame into per-cycle
// LED levels from the protocol rules; one process compares every cycle.
module tb_irsender_wb8;

   localparam int CLOCKFREQ   = 160000;
   localparam int CARRIERFREQ = 8000;
   localparam int UNIT        = 90;
   localparam int HALF        = 10;
`ifdef IRSENDER_CARRIER_EN
   localparam bit CARRIER = 1'b1;
`else
   localparam bit CARRIER = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic led;
   irsender_wb8_if bus();

   irsender_wb8 #(.CLOCKFREQ(CLOCKFREQ), .CARRIERFREQ(CARRIERFREQ)) dut (
      .I_wb_clk (clk),
      .I_reset  (rst),
      .wb       (bus.slave),
      .O_ir_led (led)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   bit run = 1'b0;
   bit abandon = 1'b0;
   bit exp_q[$];
   bit cmp_e;
   logic [7:0] m_addr = 0, m_hi = 0, m_cmd = 0;
   logic       m_ext = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Per-cycle LED compare; empty queue means the transmitter must be idle and dark
   always @(negedge clk) begin
      if (run && !abandon) begin
         cmp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
         checks++;
         if (led === cmp_e) passes++;
         else begin
            $display("FAIL led: got %0b expected %0b (%0d cycles left in frame)",
                     led, cmp_e, exp_q.size());
            exp_q.delete();
            abandon = 1'b1;
         end
      end
   end

   function automatic logic [31:0] make_word(input logic [7:0] a, input logic [7:0] hi,
                                             input logic [7:0] c, input logic ext);
      return {~c, c, ext ? hi : ~a, a};
   endfunction

   task automatic push_seg(input bit mark, input int units);
      for (int k = 0; k < units * UNIT; k++) begin
         if (!mark)        exp_q.push_back(1'b0);
         else if (CARRIER) exp_q.push_back(((k / HALF) % 2) == 0);
         else              exp_q.push_back(1'b1);
      end
   endtask

   task automatic build_frame(input logic [31:0] w);
      push_seg(1, 16);
      push_seg(0, 8);
      for (int i = 0; i < 32; i++) begin
         push_seg(1, 1);
         push_seg(0, w[i] ? 3 : 1);
      end
      push_seg(1, 1);
   endtask

   task automatic build_repeat();
      push_seg(1, 16);
      push_seg(0, 4);
      push_seg(1, 1);
   endtask

   task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      bus.I_wb_adr = a; bus.I_wb_dat = d; bus.I_wb_we = 1'b1; bus.I_wb_stb = 1'b1;
      @(posedge clk); #1;
      bus.I_wb_stb = 1'b0; bus.I_wb_we = 1'b0;
      case (a)
         3'd0: m_addr = d;
         3'd1: m_hi   = d;
         3'd2: m_cmd  = d;
         3'd3: m_ext  = d[2];
         default: ;
      endcase
      $display("wr  adr=%0d dat=0x%02h", a, d);
   endtask

   task automatic wb_read_raw(input logic [2:0] a, output logic [7:0] d, output logic ack);
      @(posedge clk); #1;
      bus.I_wb_adr = a; bus.I_wb_we = 1'b0; bus.I_wb_stb = 1'b1;
      @(posedge clk); #1;
      bus.I_wb_stb = 1'b0;
      @(negedge clk);
      d = bus.O_wb_dat; ack = bus.O_wb_ack;
   endtask

   task automatic check_read(input logic [2:0] a, input logic [7:0] exp, input string name);
      logic [7:0] d;
      logic ack;
      wb_read_raw(a, d, ack);
      check({name, "_ack"}, 32'(ack), 32'd1);
      check(name, 32'(d), 32'(exp));
      $display("rd  adr=%0d dat=0x%02h exp=0x%02h", a, d, exp);
   endtask

   // Start write issued while idle; model waveform is queued before the first compare
   task automatic start(input logic [7:0] ctrl);
      logic [31:0] w;
      w = make_word(m_addr, m_hi, m_cmd, ctrl[2]);
      wb_write(3'd3, ctrl);
      if (ctrl[0])      build_frame(w);
      else if (ctrl[1]) build_repeat();
   endtask

   task automatic wait_frame(input string name);
      int n;
      logic [7:0] d;
      logic ack;
      n = 0;
      while (exp_q.size() > 0 && !abandon && n < 12000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 12000) begin
         checks++;
         $display("FAIL %s_timeout: frame still running after %0d cycles, required end", name, n);
         exp_q.delete();
      end
      if (abandon) begin
         d = 8'h01;
         for (int i = 0; i < 40 && d[0]; i++) begin
            repeat (500) @(posedge clk);
            wb_read_raw(3'd3, d, ack);
         end
         abandon = 1'b0;
      end
      $display("frame %s ended", name);
   endtask

   initial begin
      logic [31:0] w;
      int off;
      bus.I_wb_adr = '0; bus.I_wb_dat = '0; bus.I_wb_stb = 1'b0; bus.I_wb_we = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      run = 1'b1;
      check_read(3'd3, 8'h00, "reset_ctrl");
      check_read(3'd0, 8'h00, "reset_addr");

      // Standard frame: address 0x00, command 0x45
      wb_write(3'd0, 8'h00);
      wb_write(3'd2, 8'h45);
      check("model_word_t1", make_word(m_addr, m_hi, m_cmd, 1'b0), 32'hBA45FF00);
      start(8'h01);
      check("model_len_t1", 32'(exp_q.size()), 32'd10890);
      repeat (100) @(posedge clk);
      check_read(3'd3, 8'h01, "busy_t1");
      wait_frame("t1");
      check_read(3'd3, 8'h80, "done_t1");

      // Repeat code
      start(8'h02);
      check("model_len_rep", 32'(exp_q.size()), 32'd1890);
      wait_frame("rep");
      check_read(3'd3, 8'h80, "done_rep");

      // Extended address: second byte is ADDR_HI
      wb_write(3'd0, 8'h12);
      wb_write(3'd1, 8'h34);
      wb_write(3'd2, 8'h01);
      check("model_word_ext", make_word(m_addr, m_hi, m_cmd, 1'b1), 32'hFE013412);
      start(8'h05);
      wait_frame("ext");
      check_read(3'd3, 8'h84, "done_ext");
      check_read(3'd1, 8'h34, "addr_hi_rb");

      // Start while busy is ignored, EXT and data registers still update
      wb_write(3'd0, 8'($urandom));
      wb_write(3'd2, 8'($urandom));
      start(8'h01);
      repeat (495) @(posedge clk);
      wb_write(3'd3, 8'h05);
      wb_write(3'd2, 8'($urandom));
      check_read(3'd3, 8'h05, "busy_ignored");
      check_read(3'd2, m_cmd, "cmd_rb_busy");
      wait_frame("busy_start");
      check_read(3'd3, 8'h84, "done_busy_start");

      // Both start bits: frame wins
      wb_write(3'd0, 8'($urandom));
      wb_write(3'd2, 8'($urandom));
      start(8'h03);
      wait_frame("both");
      check_read(3'd3, 8'h80, "done_both");

      // Unmapped offsets read zero and ignore writes
      wb_write(3'd5, 8'hFF);
      check_read(3'd5, 8'h00, "unmapped5");
      check_read(3'd0, m_addr, "addr_after_unmapped");

      // Reset during the bit 10 mark
      wb_write(3'd0, 8'($urandom));
      wb_write(3'd2, 8'($urandom));
      w = make_word(m_addr, m_hi, m_cmd, 1'b0);
      start(8'h01);
      off = 24;
      for (int i = 0; i < 10; i++) off += 2 + (w[i] ? 2 : 0);
      repeat (off * UNIT + 3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      exp_q.delete();
      #1 rst = 1'b0;
      m_addr = 0; m_hi = 0; m_cmd = 0; m_ext = 0;
      @(negedge clk);
      check("led_after_reset", 32'(led), 32'd0);
      check_read(3'd3, 8'h00, "ctrl_after_reset");
      check_read(3'd0, 8'h00, "addr_after_reset");

      // Complete random frame after reset
      wb_write(3'd0, 8'($urandom));
      wb_write(3'd1, 8'($urandom));
      wb_write(3'd2, 8'($urandom));
      w = 32'($urandom_range(0, 1));
      start(8'h01 | 8'(w[0] << 2));
      wait_frame("post_reset");
      check_read(3'd3, 8'h80 | 8'(w[0] << 2), "done_post_reset");

      // Repeat code with EXT set
      start(8'h06);
      repeat (50) @(posedge clk);
      check_read(3'd3, 8'h05, "busy_rep_ext");
      wait_frame("rep_ext");
      check_read(3'd3, 8'h84, "done_rep_ext");

      repeat (5) @(posedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
